// File: rtl/config_loader_pkg.sv
//------------------------------------------------------------------------------
// config_loader_pkg
//   Shared definitions for the configuration loader:
//     - default geometry of the fpga fabric bitstream (frame width, frame
//       count, stream beat width) and default timing constants,
//     - legacy state encodings and the loader FSM state type,
//     - a helper that sizes a counter able to hold 0..max_val.
//------------------------------------------------------------------------------
package config_loader_pkg;

    // Default fabric geometry
    localparam int CL_FRAME_W       = 224;
    localparam int CL_NUM_FRAMES    = 43;
    localparam int CL_IN_W          = 8;
    localparam int CL_HOLD_CYCLES   = 2;
    localparam int CL_SETTLE_CYCLES = 10;

    // Legacy state encodings, kept so existing debug probes decode unchanged
    localparam logic [2:0] CL_ST_LOAD   = 3'd0;
    localparam logic [2:0] CL_ST_COMMIT = 3'd1;
    localparam logic [2:0] CL_ST_SETTLE = 3'd2;
    localparam logic [2:0] CL_ST_ARM    = 3'd3;
    localparam logic [2:0] CL_ST_DONE   = 3'd4;

    typedef enum logic [2:0] {
        CL_LOAD   = CL_ST_LOAD,
        CL_COMMIT = CL_ST_COMMIT,
        CL_SETTLE = CL_ST_SETTLE,
        CL_ARM    = CL_ST_ARM,
        CL_DONE   = CL_ST_DONE
    } cl_state_t;

    // Width of a counter that must represent every value in 0..max_val.
    // Never returns zero so that degenerate parameters still give a legal vector.
    function automatic int cl_cnt_w(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage : config_loader_pkg

// File: rtl/config_loader_if.sv
//------------------------------------------------------------------------------
// config_loader_if
//   Valid/ready byte stream carrying the bitstream into the loader.
//     bs_valid : beat valid            (source -> loader)
//     bs_data  : beat payload, IN_W    (source -> loader)
//     bs_ready : loader accepts a beat (loader -> source)
//   modport master : bitstream source
//   modport slave  : config_loader
//------------------------------------------------------------------------------
interface config_loader_if
    import config_loader_pkg::*;
#(
    parameter int IN_W = CL_IN_W
) ();

    logic            bs_valid;
    logic [IN_W-1:0] bs_data;
    logic            bs_ready;

    modport master (
        output bs_valid,
        output bs_data,
        input  bs_ready
    );

    modport slave (
        input  bs_valid,
        input  bs_data,
        output bs_ready
    );

endinterface : config_loader_if

// File: rtl/config_loader_frame_assembler.sv
//------------------------------------------------------------------------------
// frame_assembler
//   Packs IN_W-bit beats MSB first into a FRAME_W-bit frame. Beat k of a
//   frame ends up in bits [FRAME_W-1-k*IN_W -: IN_W].
//   Ports:
//     clock, rst  : clock and asynchronous active-high reset
//     beat_valid  : a beat transfers this cycle
//     beat_data   : the beat payload
//     frame_data  : frame including the beat transferring this cycle
//     frame_done  : single-cycle pulse with the last beat of a frame;
//                   frame_data is the completed frame in that cycle
//   Partial data and beat_cnt are held while beat_valid is low.
//------------------------------------------------------------------------------
module frame_assembler
    import config_loader_pkg::*;
#(
    parameter int FRAME_W = CL_FRAME_W,
    parameter int IN_W    = CL_IN_W
) (
    input  logic               clock,
    input  logic               rst,
    input  logic               beat_valid,
    input  logic [IN_W-1:0]    beat_data,
    output logic [FRAME_W-1:0] frame_data,
    output logic               frame_done
);

    localparam int BEATS = FRAME_W / IN_W;
    localparam int CNT_W = cl_cnt_w(BEATS - 1);

    logic [FRAME_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic               last_beat;

    // Shifting left once per beat puts the first beat of the frame at the
    // top after BEATS beats, which is the MSB-first placement.
    always_comb begin
        shift_d    = shift_q;
        beat_cnt_d = beat_cnt_q;
        last_beat  = (beat_cnt_q == CNT_W'(BEATS - 1));
        if (beat_valid) begin
            shift_d    = (shift_q << IN_W) | FRAME_W'(beat_data);
            beat_cnt_d = last_beat ? '0 : beat_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            shift_q    <= '0;
            beat_cnt_q <= '0;
        end else begin
            shift_q    <= shift_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // Exposing the next-state value lets the top capture the frame in the
    // same edge that accepts its last beat.
    assign frame_data = shift_d;
    assign frame_done = beat_valid && last_beat;

endmodule : frame_assembler

// File: rtl/config_loader.sv
//------------------------------------------------------------------------------
// config_loader
//   Receives the fabric bitstream as a valid/ready stream, assembles frames
//   and writes each into the fabric with a one-hot configs_en strobe held for
//   HOLD_CYCLES. After the last frame it waits SETTLE_CYCLES, raises ff_en,
//   then rdy one cycle later. A restart pulse in DONE reloads from frame 0.
//   Ports:
//     clock      : rising-edge clock
//     rst        : asynchronous active-high reset
//     bs         : bitstream stream (slave side), bs_ready high only in LOAD
//     restart    : reload request, honoured only in DONE
//     configs_in : frame data to the fabric, held until the next commit
//     configs_en : one-hot frame write strobe
//     ff_en      : fabric flip-flop enable
//     rdy        : configuration complete
//------------------------------------------------------------------------------
module config_loader
    import config_loader_pkg::*;
#(
    parameter int FRAME_W       = CL_FRAME_W,
    parameter int NUM_FRAMES    = CL_NUM_FRAMES,
    parameter int IN_W          = CL_IN_W,
    parameter int HOLD_CYCLES   = CL_HOLD_CYCLES,
    parameter int SETTLE_CYCLES = CL_SETTLE_CYCLES
) (
    input  logic                  clock,
    input  logic                  rst,
    config_loader_if.slave        bs,
    input  logic                  restart,
    output logic [FRAME_W-1:0]    configs_in,
    output logic [NUM_FRAMES-1:0] configs_en,
    output logic                  ff_en,
    output logic                  rdy
);

    localparam int IDX_W    = cl_cnt_w(NUM_FRAMES);
    localparam int HOLD_W   = cl_cnt_w(HOLD_CYCLES - 1);
    localparam int SETTLE_W = cl_cnt_w(SETTLE_CYCLES - 1);

    cl_state_t             state_q, state_d;
    logic [IDX_W-1:0]      frame_idx_q, frame_idx_d;
    logic [HOLD_W-1:0]     hold_cnt_q, hold_cnt_d;
    logic [SETTLE_W-1:0]   settle_cnt_q, settle_cnt_d;
    logic [FRAME_W-1:0]    configs_in_q, configs_in_d;
    logic [NUM_FRAMES-1:0] configs_en_q, configs_en_d;
    logic                  ff_en_q, ff_en_d;
    logic                  rdy_q, rdy_d;

    logic                  beat_accept;
    logic                  frame_done;
    logic [FRAME_W-1:0]    frame_data;
    logic                  last_frame;

    // Ready is a pure state decode so the source never sees a combinational
    // path from bs_valid.
    assign bs.bs_ready  = (state_q == CL_LOAD);
    assign beat_accept  = bs.bs_valid && bs.bs_ready;
    assign last_frame   = (frame_idx_q == IDX_W'(NUM_FRAMES - 1));

    frame_assembler #(
        .FRAME_W (FRAME_W),
        .IN_W    (IN_W)
    ) u_frame_assembler (
        .clock      (clock),
        .rst        (rst),
        .beat_valid (beat_accept),
        .beat_data  (bs.bs_data),
        .frame_data (frame_data),
        .frame_done (frame_done)
    );

    always_comb begin
        state_d      = state_q;
        frame_idx_d  = frame_idx_q;
        hold_cnt_d   = hold_cnt_q;
        settle_cnt_d = settle_cnt_q;
        configs_in_d = configs_in_q;
        configs_en_d = configs_en_q;
        ff_en_d      = ff_en_q;
        rdy_d        = rdy_q;

        unique case (state_q)
            CL_LOAD: begin
                if (frame_done) begin
                    configs_in_d = frame_data;
                    configs_en_d = NUM_FRAMES'(1) << frame_idx_q;
                    hold_cnt_d   = '0;
                    state_d      = CL_COMMIT;
                end
            end

            CL_COMMIT: begin
                // The strobe went high on entry, so it is dropped on the
                // HOLD_CYCLES-th edge spent here.
                if (hold_cnt_q == HOLD_W'(HOLD_CYCLES - 1)) begin
                    configs_en_d = '0;
                    frame_idx_d  = frame_idx_q + IDX_W'(1);
                    settle_cnt_d = '0;
                    state_d      = last_frame ? CL_SETTLE : CL_LOAD;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end

            CL_SETTLE: begin
                if (settle_cnt_q == SETTLE_W'(SETTLE_CYCLES - 1)) begin
                    ff_en_d = 1'b1;
                    state_d = CL_ARM;
                end else begin
                    settle_cnt_d = settle_cnt_q + SETTLE_W'(1);
                end
            end

            CL_ARM: begin
                rdy_d   = 1'b1;
                state_d = CL_DONE;
            end

            CL_DONE: begin
                if (restart) begin
                    ff_en_d     = 1'b0;
                    rdy_d       = 1'b0;
                    frame_idx_d = '0;
                    state_d     = CL_LOAD;
                end
            end

            default: begin
                state_d = CL_LOAD;
            end
        endcase
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q      <= CL_LOAD;
            frame_idx_q  <= '0;
            hold_cnt_q   <= '0;
            settle_cnt_q <= '0;
            configs_in_q <= '0;
            configs_en_q <= '0;
            ff_en_q      <= 1'b0;
            rdy_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_idx_q  <= frame_idx_d;
            hold_cnt_q   <= hold_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            configs_in_q <= configs_in_d;
            configs_en_q <= configs_en_d;
            ff_en_q      <= ff_en_d;
            rdy_q        <= rdy_d;
        end
    end

    assign configs_in = configs_in_q;
    assign configs_en = configs_en_q;
    assign ff_en      = ff_en_q;
    assign rdy        = rdy_q;

endmodule : config_loader

// File: tb/tb_config_loader.sv
//------------------------------------------------------------------------------
// tb_config_loader
//   Two loaders: a small one (16-bit frames, 3 frames, hold 2, settle 4) for
//   the directed scenarios and a default-sized one for a random bitstream.
//   Expected frames/strobes are pushed when the last beat of a frame is
//   driven and popped when the loader raises a new configs_en.
//------------------------------------------------------------------------------
module tb_config_loader;
    import config_loader_pkg::*;

    localparam int S_FW   = 16;
    localparam int S_NF   = 3;
    localparam int S_IW   = 8;
    localparam int S_HOLD = 2;
    localparam int S_SET  = 4;
    localparam int S_BEATS = S_FW / S_IW;

    localparam int B_FW   = CL_FRAME_W;
    localparam int B_NF   = CL_NUM_FRAMES;
    localparam int B_IW   = CL_IN_W;
    localparam int B_HOLD = CL_HOLD_CYCLES;
    localparam int B_BEATS = B_FW / B_IW;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic rst_s = 1'b1, rst_b = 1'b1;
    logic restart_s = 1'b0, restart_b = 1'b0;

    logic [S_FW-1:0] cin_s;
    logic [S_NF-1:0] en_s;
    logic            ff_s, rdy_s;
    logic [B_FW-1:0] cin_b;
    logic [B_NF-1:0] en_b;
    logic            ff_b, rdy_b;

    config_loader_if #(.IN_W(S_IW)) bs_s ();
    config_loader_if #(.IN_W(B_IW)) bs_b ();

    config_loader #(
        .FRAME_W       (S_FW),
        .NUM_FRAMES    (S_NF),
        .IN_W          (S_IW),
        .HOLD_CYCLES   (S_HOLD),
        .SETTLE_CYCLES (S_SET)
    ) dut_s (
        .clock      (clock),
        .rst        (rst_s),
        .bs         (bs_s),
        .restart    (restart_s),
        .configs_in (cin_s),
        .configs_en (en_s),
        .ff_en      (ff_s),
        .rdy        (rdy_s)
    );

    config_loader dut_b (
        .clock      (clock),
        .rst        (rst_b),
        .bs         (bs_b),
        .restart    (restart_b),
        .configs_in (cin_b),
        .configs_en (en_b),
        .ff_en      (ff_b),
        .rdy        (rdy_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboards and stimulus-side models
    logic [255:0] exp_d_s[$];
    logic [63:0]  exp_e_s[$];
    logic [7:0]   m_bytes_s[$];
    int           m_idx_s = 0;
    logic [255:0] exp_d_b[$];
    logic [63:0]  exp_e_b[$];
    logic [7:0]   m_bytes_b[$];
    int           m_idx_b = 0;

    // Monitor state
    int           cyc = 0;
    logic [S_NF-1:0] prev_en_s = '0;
    logic         prev_ff_s = 1'b0, prev_rdy_s = 1'b0;
    int           hold_s = 0;
    int           commit_cyc_s[$];
    int           en_drop_cyc_s = 0, ff_rise_cyc_s = 0, rdy_rise_cyc_s = 0;
    logic [B_NF-1:0] prev_en_b = '0;
    int           hold_b = 0;
    int           n_commit_b = 0;

    // Build a frame from its beats using the MSB-first placement rule.
    function automatic logic [255:0] pack(input logic [7:0] bytes[$], input int fw);
        logic [255:0] f;
        f = '0;
        for (int k = 0; k < bytes.size(); k++)
            f = f | (256'(bytes[k]) << (fw - 8 * (k + 1)));
        return f;
    endfunction

    task automatic mon_s();
        if (rst_s) begin
            prev_en_s  = '0;
            prev_ff_s  = 1'b0;
            prev_rdy_s = 1'b0;
            hold_s     = 0;
            return;
        end
        if (en_s != '0 && en_s != prev_en_s) begin
            if (exp_d_s.size() == 0) begin
                check("s_unexpected_commit", 256'(en_s), 256'(0));
            end else begin
                check("s_frame", 256'(cin_s), exp_d_s.pop_front());
                check("s_en", 256'(en_s), 256'(exp_e_s.pop_front()));
            end
            commit_cyc_s.push_back(cyc);
            hold_s = 0;
        end
        if (en_s != '0) hold_s++;
        if (en_s == '0 && prev_en_s != '0) begin
            check("s_hold_len", 256'(hold_s), 256'(S_HOLD));
            en_drop_cyc_s = cyc;
        end
        if ($countones(en_s) > 1) check("s_onehot", 256'($countones(en_s)), 256'(1));
        if (ff_s && en_s != '0) check("s_ff_overlap", 256'(en_s), 256'(0));
        if (ff_s && !prev_ff_s) ff_rise_cyc_s = cyc;
        if (rdy_s && !prev_rdy_s) rdy_rise_cyc_s = cyc;
        prev_en_s  = en_s;
        prev_ff_s  = ff_s;
        prev_rdy_s = rdy_s;
    endtask

    task automatic mon_b();
        if (rst_b) begin
            prev_en_b = '0;
            hold_b    = 0;
            return;
        end
        if (en_b != '0 && en_b != prev_en_b) begin
            n_commit_b++;
            if (exp_d_b.size() == 0) begin
                check("b_unexpected_commit", 256'(en_b), 256'(0));
            end else begin
                check("b_frame", 256'(cin_b), exp_d_b.pop_front());
                check("b_en", 256'(en_b), 256'(exp_e_b.pop_front()));
            end
            hold_b = 0;
        end
        if (en_b != '0) hold_b++;
        if (en_b == '0 && prev_en_b != '0) check("b_hold_len", 256'(hold_b), 256'(B_HOLD));
        if ($countones(en_b) > 1) check("b_onehot", 256'($countones(en_b)), 256'(1));
        if (ff_b && en_b != '0) check("b_ff_overlap", 256'(en_b), 256'(0));
        prev_en_b = en_b;
    endtask

    initial begin
        forever begin
            @(negedge clock);
            cyc++;
            mon_s();
            mon_b();
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Stimulus helpers; all are entered and left on a falling edge.
    task automatic clear_model_s();
        exp_d_s.delete();
        exp_e_s.delete();
        m_bytes_s.delete();
        commit_cyc_s.delete();
        m_idx_s = 0;
    endtask

    task automatic reset_s();
        rst_s = 1'b1;
        bs_s.bs_valid = 1'b0;
        clear_model_s();
        repeat (2) @(negedge clock);
        rst_s = 1'b0;
        @(negedge clock);
    endtask

    task automatic send_s(input logic [7:0] b, input bit gap, input bit rs);
        int budget;
        if (gap) begin
            bs_s.bs_valid = 1'b0;
            @(negedge clock);
        end
        bs_s.bs_valid = 1'b1;
        bs_s.bs_data  = b;
        restart_s     = rs;
        budget = 50;
        while (!bs_s.bs_ready && budget > 0) begin
            @(negedge clock);
            budget--;
        end
        if (budget == 0) check("s_ready_timeout", 256'(0), 256'(1));
        m_bytes_s.push_back(b);
        if (m_bytes_s.size() == S_BEATS) begin
            exp_d_s.push_back(pack(m_bytes_s, S_FW));
            exp_e_s.push_back(64'(1) << m_idx_s);
            m_idx_s++;
            m_bytes_s.delete();
        end
        @(negedge clock);
        restart_s = 1'b0;
    endtask

    task automatic stream_s(input logic [7:0] bytes[$], input bit gap, input int rs_at);
        for (int i = 0; i < bytes.size(); i++) send_s(bytes[i], gap, i == rs_at);
        bs_s.bs_valid = 1'b0;
    endtask

    task automatic wait_rdy_s(input string tag);
        int budget = 200;
        while (!rdy_s && budget > 0) begin
            @(negedge clock);
            budget--;
        end
        check(tag, 256'(rdy_s), 256'(1));
        check({tag, "_sb_empty"}, 256'(exp_d_s.size()), 256'(0));
    endtask

    task automatic send_b(input logic [7:0] b);
        int budget = 50;
        bs_b.bs_valid = 1'b1;
        bs_b.bs_data  = b;
        while (!bs_b.bs_ready && budget > 0) begin
            @(negedge clock);
            budget--;
        end
        if (budget == 0) check("b_ready_timeout", 256'(0), 256'(1));
        m_bytes_b.push_back(b);
        if (m_bytes_b.size() == B_BEATS) begin
            exp_d_b.push_back(pack(m_bytes_b, B_FW));
            exp_e_b.push_back(64'(1) << m_idx_b);
            m_idx_b++;
            m_bytes_b.delete();
        end
        @(negedge clock);
    endtask

    logic [7:0] stream1[$] = '{8'hA5, 8'h3C, 8'h0F, 8'hF0, 8'h81, 8'h7E};
    logic [7:0] stream3[$] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    logic [7:0] stream4[$] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h80};
    logic [7:0] partial[$] = '{8'hA5, 8'h3C, 8'h0F};

    initial begin
        bs_s.bs_valid = 1'b0;
        bs_s.bs_data  = '0;
        bs_b.bs_valid = 1'b0;
        bs_b.bs_data  = '0;
        repeat (3) @(negedge clock);
        rst_s = 1'b0;
        rst_b = 1'b0;
        @(negedge clock);

        // Reset state
        check("rst_cin", 256'(cin_s), 256'(0));
        check("rst_en", 256'(en_s), 256'(0));
        check("rst_ff", 256'(ff_s), 256'(0));
        check("rst_rdy", 256'(rdy_s), 256'(0));
        check("rst_ready", 256'(bs_s.bs_ready), 256'(1));

        // Scenario 1: continuous stream, with throughput and settle timing
        stream_s(stream1, 1'b0, -1);
        wait_rdy_s("s1_rdy");
        check("s1_commits", 256'(commit_cyc_s.size()), 256'(S_NF));
        if (commit_cyc_s.size() == S_NF) begin
            check("s1_gap01", 256'(commit_cyc_s[1] - commit_cyc_s[0]), 256'(S_BEATS + S_HOLD));
            check("s1_gap12", 256'(commit_cyc_s[2] - commit_cyc_s[1]), 256'(S_BEATS + S_HOLD));
        end
        check("s1_settle", 256'(ff_rise_cyc_s - en_drop_cyc_s), 256'(S_SET));
        check("s1_arm", 256'(rdy_rise_cyc_s - ff_rise_cyc_s), 256'(1));
        check("s1_ff", 256'(ff_s), 256'(1));

        // Scenario 2: bs_valid toggling every other cycle
        reset_s();
        stream_s(stream1, 1'b1, -1);
        wait_rdy_s("s2_rdy");
        check("s2_settle", 256'(ff_rise_cyc_s - en_drop_cyc_s), 256'(S_SET));

        // Scenario 3: asynchronous reset after byte 0F of frame 1
        reset_s();
        stream_s(partial, 1'b0, -1);
        #2;
        rst_s = 1'b1;
        clear_model_s();
        #1;
        check("s3_cin", 256'(cin_s), 256'(0));
        check("s3_en", 256'(en_s), 256'(0));
        check("s3_ff", 256'(ff_s), 256'(0));
        check("s3_rdy", 256'(rdy_s), 256'(0));
        check("s3_ready", 256'(bs_s.bs_ready), 256'(1));
        @(negedge clock);
        @(negedge clock);
        rst_s = 1'b0;
        @(negedge clock);
        stream_s(stream3, 1'b0, -1);
        wait_rdy_s("s3_rdy");

        // Scenario 4: DONE ignores beats, honours restart; restart in LOAD ignored
        bs_s.bs_valid = 1'b1;
        bs_s.bs_data  = 8'h5A;
        repeat (3) @(negedge clock);
        check("s4_done_ready", 256'(bs_s.bs_ready), 256'(0));
        bs_s.bs_valid = 1'b0;
        check("s4_done_ff", 256'(ff_s), 256'(1));
        restart_s = 1'b1;
        @(negedge clock);
        restart_s = 1'b0;
        check("s4_ff_drop", 256'(ff_s), 256'(0));
        check("s4_rdy_drop", 256'(rdy_s), 256'(0));
        check("s4_ready", 256'(bs_s.bs_ready), 256'(1));
        m_idx_s = 0;
        restart_s = 1'b1;
        @(negedge clock);
        restart_s = 1'b0;
        check("s4_load_restart_ready", 256'(bs_s.bs_ready), 256'(1));
        stream_s(stream4, 1'b0, 2);
        wait_rdy_s("s4_rdy");

        // Scenario 5: default geometry, random bitstream
        for (int i = 0; i < B_NF * B_BEATS; i++) send_b(8'($urandom_range(0, 255)));
        bs_b.bs_valid = 1'b0;
        begin
            int budget = 200;
            while (!rdy_b && budget > 0) begin
                @(negedge clock);
                budget--;
            end
        end
        check("s5_rdy", 256'(rdy_b), 256'(1));
        check("s5_commits", 256'(n_commit_b), 256'(B_NF));
        check("s5_sb_empty", 256'(exp_d_b.size()), 256'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_config_loader

// File: doc/config_loader.md
# config_loader

Synthesizable configuration loader for the `fpga` fabric: the receiving end of the bitstream that bench wrappers currently stream in from a `.bs` file. It accepts the bitstream as a valid/ready byte stream and assembles `FRAME_W`-bit frames. Each frame is written into the fabric by driving `configs_in` with a one-hot `configs_en` strobe. After the last frame it releases `ff_en`, then raises `rdy`.

## Interface
Parameters:
- `FRAME_W`, 224: config frame width; must be a multiple of `IN_W`.
- `NUM_FRAMES`, 43: frames per bitstream, which is also the `configs_en` width.
- `IN_W`, 8: stream beat width.
- `HOLD_CYCLES`, 2: cycles each `configs_en` bit is held high; ≥1.
- `SETTLE_CYCLES`, 10: idle cycles after the last frame before `ff_en`; ≥1.

Ports:
- `clock` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `bs_valid` in 1: stream beat valid.
- `bs_data` in `IN_W`: stream beat.
- `bs_ready` out 1: loader accepts a beat.
- `restart` in 1: single-cycle request to reload; honoured only in DONE.
- `configs_in` out `FRAME_W`: frame data to the fabric.
- `configs_en` out `NUM_FRAMES`: one-hot frame write strobe.
- `ff_en` out 1: fabric flip-flop enable.
- `rdy` out 1: configuration complete.

## Operation
- States: LOAD, COMMIT, SETTLE, ARM, DONE.
- Reset state is LOAD with `frame_idx`=0 and `beat_cnt`=0.
- `bs_ready` is asserted only in LOAD and is a direct decode of the state.
- A beat transfers on `bs_valid && bs_ready`.

Frame assembly:
- Data is MSB first. Beat k of a frame lands in bits [`FRAME_W`-1-k·`IN_W` -: `IN_W`].
- `BEATS` = `FRAME_W`/`IN_W`.

LOAD:
- On the transfer of beat `BEATS`-1:
  - `configs_in` <= the completed frame,
  - `configs_en` <= 1 << `frame_idx`,
  - `beat_cnt` <= 0,
  - go to COMMIT.

COMMIT:
- Hold `configs_en` for exactly `HOLD_CYCLES` cycles.
- Then `configs_en` <= 0 and `frame_idx`++.
- Go to SETTLE if the completed frame was frame `NUM_FRAMES`-1, otherwise return to LOAD.
- `configs_in` keeps its value until the next commit.

SETTLE:
- Count `SETTLE_CYCLES`, then `ff_en` <= 1 and go to ARM.

ARM:
- One cycle; `rdy` <= 1, go to DONE.

DONE:
- Outputs are held. Stream beats are not accepted.
- On `restart`: `ff_en` <= 0, `rdy` <= 0, `frame_idx` <= 0, go to LOAD.
- `restart` in any other state is ignored.

Reset values: `configs_in`=0, `configs_en`=0, `ff_en`=0, `rdy`=0, `bs_ready`=1.

## Timing
- Assertion of `rst` at any point clears all state asynchronously and discards any partial frame. Reload starts from frame 0.
- The loader accepts one beat per cycle and holds the stream with no stall inside a frame.
- If the last beat of a frame is accepted at edge t:
  - `configs_en` is nonzero from t to t+`HOLD_CYCLES`,
  - it is zero after edge t+`HOLD_CYCLES`,
  - `bs_ready` returns in the same cycle.
- Frame throughput is `BEATS`+`HOLD_CYCLES` cycles.
- If the last beat of the last frame is accepted at edge t:
  - `ff_en` rises at edge t+`HOLD_CYCLES`+`SETTLE_CYCLES`,
  - `rdy` rises one edge later.
- `configs_en` is never more than one-hot, and is never nonzero outside COMMIT.
- `ff_en` is never 1 while `configs_en` is nonzero.
- A `bs_valid` gap mid-frame stalls assembly; `beat_cnt` and partial data are retained.

## Structure
- Package `config_loader_pkg` holds:
  - the state enum `cl_state_t`,
  - default constants `CL_FRAME_W`, `CL_NUM_FRAMES`, `CL_IN_W`.
- Sub-module `frame_assembler` contains the beat shift register and `beat_cnt`. It outputs the completed frame and a `frame_done` pulse.
- The top-level FSM holds `frame_idx`, the hold counter and the settle counter.
- Counter widths are set by `$clog2` of the respective maximum.

## Test plan
Scenarios 1–4 use `FRAME_W`=16, `IN_W`=8, `NUM_FRAMES`=3, `HOLD_CYCLES`=2, `SETTLE_CYCLES`=4.

1. Reset, then stream bytes A5,3C,0F,F0,81,7E continuously:
   - `configs_in` = A53C with `configs_en`=001 for 2 cycles,
   - then 0FF0 with 010, then 817E with 100,
   - `ff_en` 4 cycles after the last `configs_en` drops, `rdy` one cycle later.
2. Toggle `bs_valid` every other cycle during the same stream. Frames and `configs_en` order are identical to scenario 1; only the timing stretches.
3. Reset mid-frame 1, after byte 0F:
   - all outputs return to 0 immediately, `bs_ready`=1,
   - a fresh 6-byte stream yields frame 0 at `configs_en`=001.
4. `restart` in DONE:
   - `ff_en` and `rdy` drop next cycle, `bs_ready`=1,
   - a new stream reloads from `configs_en`=001.
   - `restart` pulsed during LOAD has no effect.
5. Defaults (224/43/8): stream a random 1204-byte bitstream. Check that:
   - each of the 43 frames matches MSB-first packing,
   - `configs_en` walks 1<<0 through 1<<42,
   - `rdy` rises after the last frame.
